// File: rtl/debug_trace_collector.sv
// debug_trace_collector
// Retirement-end consumer of the debug pipeline side-channel. Each cycle it
// samples the tick/instruction pair leaving the last debug pipeline register.
// Bubbles (inst == 0) and stalled cycles are ignored. Retired instructions go
// into a circular FIFO, which drains over a valid/ready word stream. Entries
// that arrive while the FIFO is full are dropped and counted.
//
// Build option: define DEBUG_TRACE_TIMESTAMP_EN to store the tick with each
// entry and send every entry as two beats (tick, then inst). When it is left
// undefined, each entry is a single inst beat.
//
// Ports:
//   i_clock      rising-edge clock
//   i_reset      synchronous active-low reset
//   i_stall      pipeline stall; the input pair is a held copy and is ignored
//   i_dbgTick    tick number of the retiring instruction
//   i_dbgInst    retiring instruction; zero marks a bubble or flush
//   o_trcData    trace word
//   o_trcValid   trace word valid
//   o_trcLast    last word of the current entry
//   i_trcReady   trace sink accepts the word
//   i_clear      clears the overflow flag and the drop counter
//   o_overflow   sticky flag: at least one entry dropped
//   o_dropCount  dropped entries, saturating at 16'hFFFF
//   o_level      number of entries currently stored
module debug_trace_collector #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_stall,
  input  logic [31:0]              i_dbgTick,
  input  logic [31:0]              i_dbgInst,
  output logic [31:0]              o_trcData,
  output logic                     o_trcValid,
  output logic                     o_trcLast,
  input  logic                     i_trcReady,
  input  logic                     i_clear,
  output logic                     o_overflow,
  output logic [15:0]              o_dropCount,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WORD_W = 32;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  localparam int unsigned ENTRY_W = 2 * WORD_W;
`else
  localparam int unsigned ENTRY_W = WORD_W;
`endif

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic               push_c;
  logic               full_c;
  logic               push_ok_c;
  logic               drop_c;
  logic               pop_c;
  logic [ENTRY_W-1:0] head_c;
  logic [ENTRY_W-1:0] entry_c;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  typedef enum logic {BEAT_TICK = 1'b0, BEAT_INST = 1'b1} beat_e;
  beat_e beat_q, beat_d;
  assign entry_c = {i_dbgTick, i_dbgInst};
`else
  // The tick is not stored in this build.
  logic unused_tick_c;
  assign unused_tick_c = ^i_dbgTick;
  assign entry_c       = i_dbgInst;
`endif

  // Capture qualification. "Full" uses the pre-edge level, so a pop in the
  // same cycle does not make room for the new entry.
  assign push_c    = i_reset & ~i_stall & (i_dbgInst != '0);
  assign full_c    = (level_q == LVL_W'(DEPTH));
  assign push_ok_c = push_c & ~full_c;
  assign drop_c    = push_c & full_c;
  assign head_c    = mem_q[rd_ptr_q];

  assign o_trcValid  = (level_q != '0);
  assign o_level     = level_q;
  assign o_overflow  = overflow_q;
  assign o_dropCount = drop_cnt_q;

  // Beat sequencing and trace word selection. The words come only from
  // registered state, which keeps them stable while the sink holds off.
  always_comb begin
    pop_c     = 1'b0;
    o_trcData = '0;
    o_trcLast = 1'b0;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    beat_d    = beat_q;
    if (o_trcValid) begin
      case (beat_q)
        BEAT_TICK: begin
          o_trcData = head_c[ENTRY_W-1:WORD_W];
          if (i_trcReady) beat_d = BEAT_INST;
        end
        BEAT_INST: begin
          o_trcData = head_c[WORD_W-1:0];
          o_trcLast = 1'b1;
          if (i_trcReady) begin
            beat_d = BEAT_TICK;
            pop_c  = 1'b1;
          end
        end
        default: beat_d = BEAT_TICK;
      endcase
    end
`else
    if (o_trcValid) begin
      o_trcData = head_c;
      o_trcLast = 1'b1;
      pop_c     = i_trcReady;
    end
`endif
  end

  // Pointer, level and drop bookkeeping. A clear wins over a drop in the same cycle.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LVL_W'(push_ok_c) - LVL_W'(pop_c);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (i_clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // State registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
      beat_q     <= BEAT_TICK;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
      beat_q     <= beat_d;
`endif
    end
  end

  // Entry storage. It is not reset; the outputs are gated by the level.
  always_ff @(posedge i_clock) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= entry_c;
  end

endmodule
